// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin ALU/LSU writeback arbiter with a registered register-file write and a pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDR_WIDTH-1:0]    lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  input  logic                     alloc_valid,
  input  logic [ADDR_WIDTH-1:0]    alloc_rd,
  output logic                     rf_isWrite,
  output logic [ADDR_WIDTH-1:0]    rf_rd,
  output logic [DATA_WIDTH-1:0]    rf_writeData,
  output logic [2**ADDR_WIDTH-1:0] pending
);
  localparam int NREG = 2**ADDR_WIDTH;
  typedef enum logic {PRIO_ALU, PRIO_LSU} prio_t;
  prio_t prio_q, prio_d;
  logic rf_we_q, rf_we_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d, g_rd;
  logic [DATA_WIDTH-1:0] rf_data_q, rf_data_d, g_data;
  logic [NREG-1:0] pending_q, pending_d;
  logic hs;
  // grant the lone requester; under contention only the prio source; next-state for prio and write registers
  always_comb begin
    alu_ready = alu_valid && (!lsu_valid || prio_q == PRIO_ALU);
    lsu_ready = lsu_valid && (!alu_valid || prio_q == PRIO_LSU);
    hs = alu_ready || lsu_ready;
    g_rd = alu_ready ? alu_rd : lsu_rd;
    g_data = alu_ready ? alu_data : lsu_data;
    prio_d = alu_ready ? PRIO_LSU : (lsu_ready ? PRIO_ALU : prio_q);
    rf_we_d = hs && g_rd != '0;
    rf_rd_d = hs ? g_rd : rf_rd_q;
    rf_data_d = hs ? g_data : rf_data_q;
  end
  // scoreboard: a completed write clears, then an allocation sets, so a same-rd alloc wins
  always_comb begin
    pending_d = pending_q;
    if (rf_we_d) pending_d[g_rd] = 1'b0;
    if (alloc_valid && alloc_rd != '0) pending_d[alloc_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end
  // state registers; reset drops any in-flight write immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= PRIO_ALU;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_data_q <= '0;
      pending_q <= '0;
    end else begin
      prio_q <= prio_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_data_q <= rf_data_d;
      pending_q <= pending_d;
    end
  end
  assign rf_isWrite = rf_we_q;
  assign rf_rd = rf_rd_q;
  assign rf_writeData = rf_data_q;
  assign pending = pending_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_valid = 1'b0, lsu_valid = 1'b0, alloc_valid = 1'b0;
  logic alu_ready, lsu_ready, rf_isWrite;
  logic [AW-1:0] alu_rd = '0, lsu_rd = '0, alloc_rd = '0, rf_rd;
  logic [DW-1:0] alu_data = '0, lsu_data = '0, rf_writeData;
  logic [NR-1:0] pending;
  typedef struct packed {logic we; logic [AW-1:0] rd; logic [DW-1:0] data;} wr_t;
  wr_t q[$];
  int errors = 0;
  int checks = 0;
  logic m_prio;
  logic [NR-1:0] m_pend;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic last_alu;
  logic [NR-1:0] saved;
  int grants[4];
  int rds[4];
  int a, l;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rf_isWrite(rf_isWrite), .rf_rd(rf_rd), .rf_writeData(rf_writeData), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prio = 1'b0;
    m_pend = '0;
    m_rd = '0;
    m_data = '0;
    q.delete();
  endtask

  task automatic tick();
    logic ea, el;
    wr_t w;
    logic [NR-1:0] nxt;
    #1;
    ea = alu_valid && (!lsu_valid || !m_prio);
    el = lsu_valid && (!alu_valid || m_prio);
    chk("alu_ready", alu_ready, ea);
    chk("lsu_ready", lsu_ready, el);
    last_alu = ea;
    nxt = m_pend;
    if (ea || el) begin
      w = ea ? '{alu_rd != '0, alu_rd, alu_data} : '{lsu_rd != '0, lsu_rd, lsu_data};
      q.push_back(w);
      if (w.we) nxt[w.rd] = 1'b0;
    end
    if (alloc_valid && alloc_rd != '0) nxt[alloc_rd] = 1'b1;
    @(posedge clk);
    #1;
    if (ea || el) begin
      w = q.pop_front();
      chk("rf_isWrite", rf_isWrite, w.we);
      chk("rf_rd", rf_rd, w.rd);
      chk("rf_writeData", rf_writeData, w.data);
      m_rd = w.rd;
      m_data = w.data;
      m_prio = ea;
    end else begin
      chk("rf_isWrite_idle", rf_isWrite, 0);
      chk("rf_rd_hold", rf_rd, m_rd);
      chk("rf_writeData_hold", rf_writeData, m_data);
    end
    m_pend = nxt;
    chk("pending", pending, m_pend);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_isWrite", rf_isWrite, 0);
    chk("reset_rd", rf_rd, 0);
    chk("reset_data", rf_writeData, 0);
    chk("reset_pending", pending, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // contention: grants must alternate ALU,LSU,ALU,LSU
    a = 0;
    l = 0;
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = AW'(1 + a);
      alu_data = 32'hA000_0000 + 32'(a);
      lsu_rd = AW'(11 + l);
      lsu_data = 32'hB000_0000 + 32'(l);
      tick();
      grants[i] = last_alu ? 0 : 1;
      rds[i] = int'(rf_rd);
      if (last_alu) a++; else l++;
    end
    chk("rr_grant0", 64'(grants[0]), 0);
    chk("rr_grant1", 64'(grants[1]), 1);
    chk("rr_grant2", 64'(grants[2]), 0);
    chk("rr_grant3", 64'(grants[3]), 1);
    chk("rr_rd0", 64'(rds[0]), 1);
    chk("rr_rd1", 64'(rds[1]), 11);
    chk("rr_rd2", 64'(rds[2]), 2);
    chk("rr_rd3", 64'(rds[3]), 12);
    // single source
    lsu_valid = 1'b0;
    alu_rd = 5;
    alu_data = 32'hDEADBEEF;
    tick();
    chk("single_we", rf_isWrite, 1);
    chk("single_rd", rf_rd, 5);
    chk("single_data", rf_writeData, 32'hDEADBEEF);
    alu_valid = 1'b0;
    tick();
    // rd=0 discard
    saved = pending;
    lsu_valid = 1'b1;
    lsu_rd = 0;
    lsu_data = 32'h1234;
    tick();
    chk("rd0_we", rf_isWrite, 0);
    chk("rd0_pending", pending, saved);
    lsu_valid = 1'b0;
    // scoreboard set/clear
    alloc_valid = 1'b1;
    alloc_rd = 7;
    tick();
    chk("alloc7", pending[7], 1);
    alloc_valid = 1'b0;
    alu_valid = 1'b1;
    alu_rd = 7;
    alu_data = 32'h7777_0007;
    tick();
    chk("clear7", pending[7], 0);
    chk("clear7_we", rf_isWrite, 1);
    alu_valid = 1'b0;
    saved = pending;
    alloc_valid = 1'b1;
    alloc_rd = 0;
    tick();
    chk("alloc0", pending, saved);
    // simultaneous set/clear on the same rd: set wins
    alloc_rd = 9;
    tick();
    lsu_valid = 1'b1;
    lsu_rd = 9;
    lsu_data = 32'h9999_0009;
    tick();
    chk("same_rd_pending9", pending[9], 1);
    chk("same_rd_rf_rd", rf_rd, 9);
    lsu_valid = 1'b0;
    alloc_rd = 4;
    tick();
    alloc_rd = 3;
    alu_valid = 1'b1;
    alu_rd = 4;
    alu_data = 32'h4444_0004;
    tick();
    chk("diff_rd_pending3", pending[3], 1);
    chk("diff_rd_pending4", pending[4], 0);
    // mid-traffic reset with a write in flight
    alloc_valid = 1'b0;
    alu_rd = 6;
    alu_data = 32'h6666_0006;
    tick();
    chk("pre_reset_we", rf_isWrite, 1);
    rst_n = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("midreset_we", rf_isWrite, 0);
    chk("midreset_pending", pending, 0);
    chk("midreset_rd", rf_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    alu_rd = 2;
    lsu_rd = 3;
    #1;
    chk("post_reset_alu_ready", alu_ready, 1);
    chk("post_reset_lsu_ready", lsu_ready, 0);
    tick();
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (isWrite / rd / writeData) between two writeback sources: ALU and load/store unit (LSU).
- Uses valid/ready handshakes and a round-robin arbiter.
- The write to the register file is registered, with 1-cycle latency.
- Also maintains a pending-write scoreboard so issue logic can stall on RAW hazards against in-flight destinations.

Parameters:
DATA_WIDTH, 32, width of writeback data and register-file write data
ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU has a writeback
alu_ready  output  1  ALU writeback accepted this cycle
alu_rd  input  ADDR_WIDTH  ALU destination register
alu_data  input  DATA_WIDTH  ALU result
lsu_valid  input  1  LSU has a writeback
lsu_ready  output  1  LSU writeback accepted this cycle
lsu_rd  input  ADDR_WIDTH  LSU destination register
lsu_data  input  DATA_WIDTH  LSU load data
alloc_valid  input  1  issue stage allocates a destination
alloc_rd  input  ADDR_WIDTH  allocated destination register
rf_isWrite  output  1  register-file write enable
rf_rd  output  ADDR_WIDTH  register-file write index
rf_writeData  output  DATA_WIDTH  register-file write data
pending  output  2**ADDR_WIDTH  bit n = write to register n outstanding

Behaviour:
- Clock and reset: one clock domain, clk. Reset is rst_n, asynchronous assert, active-low, synchronous deassert by the system.
- Reset values:
  - rf_isWrite=0, rf_rd=0, rf_writeData=0.
  - pending=0.
  - Priority pointer prio=ALU.
  - alu_ready and lsu_ready are combinational and follow the grant logic immediately.
- Grant logic (combinational):
  - Neither valid: both ready=0.
  - Exactly one valid: that source gets ready=1.
  - Both valid: only the source named by prio gets ready=1.
  - alu_ready and lsu_ready are never both 1.
  - A handshake occurs when valid && ready.
- Priority update (posedge): after a handshake, prio = the non-granted source. With no handshake, prio holds.
- Source contract: a source holds valid, rd and data stable until ready. The block does not check this.
- Write path (posedge following a handshake, cycle N):
  - In cycle N+1: rf_isWrite=(granted rd != 0), rf_rd=granted rd, rf_writeData=granted data.
  - With no handshake: rf_isWrite=0; rf_rd and rf_writeData hold their previous values.
  - Back-to-back handshakes give one write per cycle, with no bubbles.
  - rd=0: the handshake completes, rf_isWrite stays 0 and the data is discarded.
- Scoreboard (posedge):
  - alloc_valid && alloc_rd!=0 sets pending[alloc_rd].
  - A handshake with rd!=0 clears pending[granted rd]. The clear lands on the same edge the rf_* registers load.
  - Alloc and clear on the same rd in the same cycle: set wins (newer producer outstanding).
  - Alloc and clear on different rds in the same cycle: both take effect.
  - pending[0] is constant 0.
  - A handshake to a register whose pending bit is already 0 is legal and leaves it 0.
  - Re-allocating an already-pending rd leaves it 1. No counting: the first completing write clears it.
- Reset mid-operation: all state returns to reset values at once. An in-flight registered write is dropped (rf_isWrite=0 while rst_n low).
- Register-file read-during-write forwarding is outside this block.

Test Plan:
- Reset: drive rst_n=0 mid-traffic with rf_isWrite=1 -> rf_isWrite=0, pending=0 within the same cycle; after release, first contention grants ALU.
- Single source: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, lsu_valid=0 -> alu_ready=1 in cycle N; in N+1 rf_isWrite=1, rf_rd=5, rf_writeData=0xDEADBEEF.
- Contention round-robin: both valid for 4 cycles (ALU rd=1..4, LSU rd=11..14, sources advance on accept) -> grants ALU,LSU,ALU,LSU; rf_rd sequence 1,11,2,12 with one write per cycle.
- rd=0 discard: lsu_valid=1, lsu_rd=0, lsu_data=0x1234 -> lsu_ready=1; next cycle rf_isWrite=0; pending unchanged.
- Scoreboard: alloc rd=7 -> pending[7]=1; ALU write rd=7 accepted -> pending[7]=0 on the same edge rf_isWrite rises; alloc rd=0 -> pending stays 0.
- Simultaneous set/clear: pending[9]=1, alloc_rd=9 and LSU write rd=9 handshake in the same cycle -> pending[9]=1 afterwards, rf_rd=9 written; separately alloc rd=3 with write rd=4 -> pending[3]=1, pending[4]=0.
